// File: rtl/scan_guard_pkg.sv
// scan_guard_pkg: shared state type and LFSR constants for the multi-chain scan guard
package scan_guard_pkg;
  typedef enum logic [1:0] {SG_LOCKED, SG_UNLOCKED, SG_LOCKOUT} sg_state_t;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/scan_guard_mc_lfsr.sv
// sg_lfsr16: 16-bit Fibonacci garbage LFSR that advances only when enabled
module sg_lfsr16
  import scan_guard_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);
  logic [LFSR_W-1:0] state_q, state_d;
  always_comb state_d = en ? lfsr_next(state_q) : state_q;
  always_ff @(posedge clk) state_q <= rst ? SEED : state_d;
  assign state = state_q;
endmodule

// File: rtl/scan_guard_mc.sv
// scan_guard_mc: multi-word key authentication gating NUM_CHAINS scan-out lanes
module scan_guard_mc
  import scan_guard_pkg::*;
#(
  parameter int               NUM_CHAINS = 4,
  parameter int               KEY_WIDTH  = 32,
  parameter int               KEY_WORDS  = 8,
  parameter int               MAX_FAIL   = 3,
  parameter int               OBFUSCATE  = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [KEY_WORDS*KEY_WIDTH-1:0]  golden_key,
  input  logic [KEY_WIDTH-1:0]            scan_key,
  input  logic                            scan_key_valid,
  input  logic                            relock,
  input  logic                            scan_enable,
  input  logic [NUM_CHAINS-1:0]           scan_in,
  output logic [NUM_CHAINS-1:0]           scan_out,
  output logic                            scan_unlock,
  output logic                            locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count,
  output logic                            key_busy
);
  localparam int IW = KEY_WORDS > 1 ? $clog2(KEY_WORDS) : 1;
  localparam int FW = $clog2(MAX_FAIL+1);
  sg_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic flag_q, flag_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic [NUM_CHAINS-1:0] scan_out_q, scan_out_d;
  logic [LFSR_W-1:0] lfsr;
  logic [KEY_WIDTH-1:0] gw [KEY_WORDS];
  logic last, miss;
  for (genvar k = 0; k < KEY_WORDS; k++) begin : g_words
    assign gw[k] = golden_key[k*KEY_WIDTH +: KEY_WIDTH];
  end
  assign last = idx_q == IW'(KEY_WORDS-1);
  assign miss = flag_q | (scan_key != gw[idx_q]);
  assign fail_inc = fail_q + FW'(1);
  sg_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (scan_enable && state_q != SG_UNLOCKED),
    .state(lfsr)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    flag_d = flag_q;
    fail_d = fail_q;
    case (state_q)
      SG_LOCKED:
        if (relock) begin
          idx_d = '0;
          flag_d = 1'b0;
        end else if (scan_key_valid) begin
          idx_d = last ? '0 : idx_q + IW'(1);
          flag_d = last ? 1'b0 : miss;
          if (last) begin
            fail_d = miss ? fail_inc : '0;
            state_d = !miss ? SG_UNLOCKED : fail_inc == FW'(MAX_FAIL) ? SG_LOCKOUT : SG_LOCKED;
          end
        end
      SG_UNLOCKED:
        if (relock) begin
          state_d = SG_LOCKED;
          idx_d = '0;
          flag_d = 1'b0;
        end
      default: ;
    endcase
  end
  always_comb
    scan_out_d = !scan_enable ? scan_out_q :
                 state_q == SG_UNLOCKED ? scan_in :
                 OBFUSCATE != 0 ? NUM_CHAINS'(lfsr) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SG_LOCKED;
      idx_q <= '0;
      flag_q <= 1'b0;
      fail_q <= '0;
      scan_out_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      flag_q <= flag_d;
      fail_q <= fail_d;
      scan_out_q <= scan_out_d;
    end
  end
  assign scan_out = scan_out_q;
  assign scan_unlock = state_q == SG_UNLOCKED;
  assign locked_out = state_q == SG_LOCKOUT;
  assign fail_count = fail_q;
  assign key_busy = idx_q != '0;
endmodule

// File: doc/scan_guard_mc.md
Name: scan_guard_mc

Overview:
Multi-chain successor to the single-chain scan-out gate in the MCSE top. It authenticates a multi-word scan key against a provisioned golden key, then releases or masks NUM_CHAINS scan-out lanes. Masked lanes output either zero or LFSR garbage. It enforces a failed-attempt lockout and relocks on request. It sits between the scan chains and the chip scan pins, beside the MCSE control unit.

Parameters:
NUM_CHAINS, 4, number of independent scan-out lanes (1..16)
KEY_WIDTH, 32, bits per key word
KEY_WORDS, 8, words per complete key
MAX_FAIL, 3, consecutive failed attempts before permanent lockout (>=1)
OBFUSCATE, 1, 1 = masked lanes emit LFSR bits; 0 = masked lanes emit 0
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit garbage LFSR

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
golden_key  in  KEY_WORDS*KEY_WIDTH  provisioned key; word 0 = bits [KEY_WIDTH-1:0]
scan_key  in  KEY_WIDTH  presented key word
scan_key_valid  in  1  scan_key is accepted this cycle
relock  in  1  pulse; forces LOCKED
scan_enable  in  1  scan shift active
scan_in  in  NUM_CHAINS  raw chain data, one bit per lane
scan_out  out  NUM_CHAINS  gated scan data
scan_unlock  out  1  high in UNLOCKED
locked_out  out  1  high in LOCKOUT
fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures
key_busy  out  1  key entry in progress (word index != 0)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: FSM=LOCKED, word index=0, mismatch flag=0, fail_count=0, lfsr=LFSR_SEED, scan_out=0, scan_unlock=0, locked_out=0, key_busy=0.
- LOCKED:
  - Each scan_key_valid compares scan_key with golden word[idx]. The mismatch flag ORs in the result. idx increments.
  - On the valid with idx==KEY_WORDS-1, the final result (flag OR current compare) is evaluated and idx resets to 0.
  - Match: next state UNLOCKED. fail_count clears to 0.
  - Mismatch: fail_count increments. If the new count equals MAX_FAIL, next state is LOCKOUT; otherwise stay in LOCKED.
- UNLOCKED: scan_key_valid is ignored. relock moves to LOCKED with idx=0 and flag=0; fail_count is unchanged.
- LOCKOUT: sticky until rst. relock and scan_key_valid are ignored.
- relock in LOCKED: clears idx and flag. It has priority over a simultaneous scan_key_valid, whose word is discarded.
- Output timing: scan_unlock and locked_out are registered state decodes. They rise one cycle after the accepting valid edge, i.e. they are visible the cycle after the final word is sampled.
- scan_out (registered, one-cycle latency):
  - scan_enable=0: hold the previous value.
  - scan_enable=1 and UNLOCKED: scan_out <= scan_in.
  - scan_enable=1 otherwise: scan_out[i] <= OBFUSCATE ? lfsr[i] : 0.
- LFSR:
  - Taps x^16+x^14+x^13+x^11+1, Fibonacci form, shift left, feedback into bit 0.
  - Advances only in cycles where scan_enable=1 and the FSM is not UNLOCKED.
  - Never reaches 0, because the seed is non-zero.
- Unlock is read from the registered state: the first scan_in pass-through is sampled in the cycle after scan_unlock rises.
- key_busy = (idx != 0).

Decomposition:
- Package scan_guard_pkg:
  - typedef enum logic [1:0] {SG_LOCKED, SG_UNLOCKED, SG_LOCKOUT} sg_state_t
  - localparam LFSR_W=16
  - LFSR tap constant
- One natural sub-module, sg_lfsr16: seed, enable, 16-bit state out.
- The key comparator and FSM stay in scan_guard_mc.

Test Plan:
- Reset, then scan_enable=1, scan_in=4'hF, OBFUSCATE=0 -> scan_out=4'h0 every cycle; scan_unlock=0.
- Eight correct words (golden word k = 32'h1000_0000+k) -> scan_unlock=1 the cycle after word 7. With scan_in=4'hA, scan_out=4'hA the following cycle. fail_count=0.
- Word 3 wrong, the rest correct -> stay LOCKED, fail_count=1. A following correct key -> UNLOCKED, fail_count=0.
- Three full wrong keys (MAX_FAIL=3) -> locked_out=1 after the 24th valid. A further correct key and relock are ignored. rst clears everything.
- OBFUSCATE=1, locked, scan_enable=1 for 3 cycles from seed 16'hACE1 -> scan_out equals the low 4 bits of successive LFSR states (matched against a reference model). scan_enable=0 freezes both the LFSR and scan_out.
- relock asserted together with the 5th key word -> idx=0, key_busy=0 next cycle. relock in UNLOCKED -> scan_unlock=0 the next cycle and masking resumes.
